// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus between the fetch unit, the instruction memory and decode.
// The master side (the fetch unit) drives:
//   PC          fetch address to the memory
//   IR          registered instruction to decode
//   IRValid     IR holds a live instruction this cycle
//   Halted      fetch has stopped on the halt encoding
//   FetchCount  saturating count of instructions accepted into IR
// The slave side (memory / pipeline / bench) drives:
//   Instruction  word at PC, combinational from the memory
//   Stall        downstream not ready; hold fetch
//   BranchTaken  taken jump resolved this cycle
//   BranchTarget redirect address, qualified by BranchTaken
//   Resume       restart fetch after a halt
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  Stall;
    logic                  BranchTaken;
    logic [DATA_WIDTH-1:0] BranchTarget;
    logic                  Resume;
    logic [DATA_WIDTH-1:0] IR;
    logic                  IRValid;
    logic                  Halted;
    logic [15:0]           FetchCount;

    modport master (
        output PC, IR, IRValid, Halted, FetchCount,
        input  Instruction, Stall, BranchTaken, BranchTarget, Resume
    );

    modport slave (
        input  PC, IR, IRValid, Halted, FetchCount,
        output Instruction, Stall, BranchTaken, BranchTarget, Resume
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Drives PC to the instruction memory, captures the combinationally returned
// word into IR, and sequences PC through normal increment, taken-branch
// redirect (one-bubble flush), stall hold and halt/resume.
// Ports:
//   Clk    system clock, all state updates on the rising edge
//   Rst_n  asynchronous active-low reset
//   bus    fetch bus (master side): PC, IR, IRValid, Halted, FetchCount out;
//          Instruction, Stall, BranchTaken, BranchTarget, Resume in
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 16'd31,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'h0000
) (
    input  logic                Clk,
    input  logic                Rst_n,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                state_reg,    state_next;
    logic [DATA_WIDTH-1:0] pc_reg,       pc_next;
    logic [DATA_WIDTH-1:0] ir_reg,       ir_next;
    logic                  ir_valid_reg, ir_valid_next;
    logic [15:0]           count_reg,    count_next;
    logic [15:0]           count_sat_inc;

    // Counter sticks at all-ones instead of wrapping back to zero.
    assign count_sat_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            count_reg    <= 16'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        count_next    = count_reg;

        case (state_reg)
            FETCH: begin
                if (bus.BranchTaken) begin
                    // Redirect wins over stall and over a halt word sitting
                    // on Instruction: the fetched word is on the wrong path.
                    pc_next       = bus.BranchTarget;
                    ir_next       = '0;
                    ir_valid_next = 1'b0;
                end else if (bus.Stall) begin
                    // hold everything
                end else if (bus.Instruction == HALT_WORD) begin
                    // The halt word itself is delivered to decode; PC stays
                    // on it so Resume continues with the following word.
                    ir_next       = HALT_WORD;
                    ir_valid_next = 1'b1;
                    count_next    = count_sat_inc;
                    state_next    = HALTED;
                end else begin
                    ir_next       = bus.Instruction;
                    ir_valid_next = 1'b1;
                    pc_next       = pc_reg + DATA_WIDTH'(1);
                    count_next    = count_sat_inc;
                end
            end
            HALTED: begin
                // Branch and stall are ignored while halted.
                ir_valid_next = 1'b0;
                if (bus.Resume) begin
                    pc_next    = pc_reg + DATA_WIDTH'(1);
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign bus.PC         = pc_reg;
    assign bus.IR         = ir_reg;
    assign bus.IRValid    = ir_valid_reg;
    assign bus.Halted     = (state_reg == HALTED);
    assign bus.FetchCount = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized phase, all checked against a behavioural model of the fetch
// stage held in plain variables.
module tb_instr_fetch_unit;

    logic Clk;
    logic Rst_n;

    instr_fetch_unit_if #(.DATA_WIDTH(16)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH(16),
        .RESET_PC  (16'd31),
        .HALT_WORD (16'h0000)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    // Instruction memory: combinational read at PC.
    logic [15:0] mem [0:65535];
    assign bus.Instruction = mem[bus.PC];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model of the architectural state.
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    bit          m_valid;
    bit          m_halted;
    int          m_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PC"},         bus.PC,                m_pc);
        check({tag, ".IR"},         bus.IR,                m_ir);
        check({tag, ".IRValid"},    {15'd0, bus.IRValid},  {15'd0, m_valid});
        check({tag, ".Halted"},     {15'd0, bus.Halted},   {15'd0, m_halted});
        check({tag, ".FetchCount"}, bus.FetchCount,        16'(m_count));
    endtask

    task automatic model_reset();
        m_pc     = 16'd31;
        m_ir     = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_count  = 0;
    endtask

    function automatic int sat_count(input int c);
        return (c < 65535) ? c + 1 : 65535;
    endfunction

    // Apply one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input bit stall, input bit br, input logic [15:0] tgt,
                        input bit resume, input string tag);
        logic [15:0] word;
        bus.Stall        = stall;
        bus.BranchTaken  = br;
        bus.BranchTarget = tgt;
        bus.Resume       = resume;
        word = mem[m_pc];
        if (m_halted) begin
            m_valid = 1'b0;
            if (resume) begin
                m_pc     = m_pc + 16'd1;
                m_halted = 1'b0;
            end
        end else if (br) begin
            m_pc    = tgt;
            m_ir    = 16'h0000;
            m_valid = 1'b0;
        end else if (!stall) begin
            m_ir    = word;
            m_valid = 1'b1;
            m_count = sat_count(m_count);
            if (word == 16'h0000) m_halted = 1'b1;
            else                  m_pc     = m_pc + 16'd1;
        end
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        Rst_n            = 1'b0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 16'h0000;
        bus.Resume       = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(1, 16'hFFFF));
        mem[31] = 16'h902D;
        mem[32] = 16'h5000;
        mem[33] = 16'h9040;
        model_reset();

        // Reset state, released between clock edges.
        #12;
        check_all("reset");
        Rst_n = 1'b1;

        // 1: straight-line fetch of 31..33.
        step(0, 0, 16'h0, 0, "seq1");
        check("seq1.IR_const", bus.IR, 16'h902D);
        check("seq1.PC_const", bus.PC, 16'd32);
        step(0, 0, 16'h0, 0, "seq2");
        check("seq2.IR_const", bus.IR, 16'h5000);
        // 2: stall two cycles with IR=5000.
        step(1, 0, 16'h0, 0, "stall1");
        check("stall1.PC_const", bus.PC, 16'd33);
        step(1, 0, 16'h0, 0, "stall2");
        check("stall2.IR_const", bus.IR, 16'h5000);
        check("stall2.cnt_const", bus.FetchCount, 16'd2);
        step(0, 0, 16'h0, 0, "seq3");
        check("seq3.IR_const", bus.IR, 16'h9040);
        check("seq3.PC_const", bus.PC, 16'd34);

        // 3: branch overrides stall.
        step(1, 1, 16'd42, 0, "br_stall");
        check("br_stall.PC_const", bus.PC, 16'd42);
        check("br_stall.valid_const", {15'd0, bus.IRValid}, 16'd0);
        step(0, 0, 16'h0, 0, "after_br");
        check("after_br.IR_mem", bus.IR, mem[42]);

        // 4: halt on word at 32, ignore branch/stall, then resume.
        mem[32] = 16'h0000;
        step(0, 1, 16'd32, 0, "br32");
        step(0, 0, 16'h0, 0, "halt");
        check("halt.Halted_const", {15'd0, bus.Halted}, 16'd1);
        check("halt.PC_const", bus.PC, 16'd32);
        step(0, 1, 16'd99, 0, "halt_br");
        step(1, 0, 16'h0, 0, "halt_stall");
        step(0, 0, 16'h0, 1, "resume");
        check("resume.PC_const", bus.PC, 16'd33);
        step(0, 0, 16'h0, 0, "post_resume");
        check("post_resume.IR_const", bus.IR, 16'h9040);
        mem[32] = 16'h5000;

        // Branch into a halt word: the redirect wins.
        mem[50] = 16'h0000;
        step(0, 1, 16'd50, 0, "br_to_halt");
        step(0, 1, 16'd60, 0, "br_over_halt");
        check("br_over_halt.Halted_const", {15'd0, bus.Halted}, 16'd0);
        mem[50] = 16'h1234;

        // 5: PC wrap and counter saturation.
        step(0, 1, 16'hFFFF, 0, "br_ffff");
        step(0, 0, 16'h0, 0, "wrap");
        check("wrap.PC_const", bus.PC, 16'h0000);
        for (int i = 0; i < 70000; i++) step(0, 0, 16'h0, 0, "long");
        check("sat.cnt_const", bus.FetchCount, 16'hFFFF);

        // Randomized phase with sparse halt words in the low region.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 16'($urandom_range(0, 255)), $urandom_range(0, 2) == 0, "rand");

        // 6: asynchronous reset between edges.
        step(0, 1, 16'd100, 0, "pre_rst");
        #3;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.PC_const", bus.PC, 16'd31);
        #2;
        Rst_n = 1'b1;
        step(0, 0, 16'h0, 0, "post_rst");
        check("post_rst.IR_mem", bus.IR, mem[31]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
